// File: rtl/s_term_ram_io_loopback_pkg.sv
// Shared fabric definitions for the south-terminating RAM I/O loopback tile:
// group-mode encodings, group geometry and configuration chain length.
package s_term_ram_io_loopback_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR     = 2'b00,
        MODE_MIRROR_REG = 2'b01,
        MODE_STRAIGHT   = 2'b10,
        MODE_ZERO       = 2'b11
    } group_mode_e;

    localparam int GROUP_COUNT = 9;
    localparam int GROUP_WIDTH = 4;
    localparam int WIRE_COUNT  = GROUP_COUNT * GROUP_WIDTH;
    localparam int CHAIN_LEN   = 18;
    localparam int COUNT_WIDTH = 5;

    // Extract the 2-bit mode of group k from a configuration word.
    function automatic group_mode_e group_mode(input logic [CHAIN_LEN-1:0] cfg, input int k);
        return group_mode_e'(cfg[2*k +: 2]);
    endfunction

endpackage

// File: rtl/s_term_ram_io_loopback_group4.sv
// One 4-wire loopback group: selects mirrored (combinational or registered),
// straight or constant-zero drive for four north-departing wires.
module loopback_group4
    import s_term_ram_io_loopback_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mirror,
    input  logic [3:0] straight,
    input  logic [1:0] sel,
    input  logic       enable,
    output logic [3:0] out
);

    logic [3:0] mirror_q;

    // Pipeline flops always track the mirrored source so that switching into
    // registered mode shows their current content immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mirror_q <= '0;
        end else begin
            mirror_q <= mirror;
        end
    end

    // Output mux; forced low whenever the tile is loading or unconfigured.
    always_comb begin
        out = '0;
        if (enable) begin
            case (group_mode_e'(sel))
                MODE_MIRROR:     out = mirror;
                MODE_MIRROR_REG: out = mirror_q;
                MODE_STRAIGHT:   out = straight;
                MODE_ZERO:       out = '0;
            endcase
        end
    end

endmodule

// File: rtl/s_term_ram_io_loopback.sv
// South-terminating RAM I/O tile: loops south-arriving wires back north in
// nine 4-wire groups, each configured through a serial shift chain.
module s_term_ram_io_loopback
    import s_term_ram_io_loopback_pkg::*;
#(
    parameter int NoConfigBits = CHAIN_LEN
) (
    input  logic CLK,
    input  logic RST,
    input  logic MODE,
    input  logic CONFin,
    output logic CONFout,
    output logic CFG_OK,
    input  logic S1END0, S1END1, S1END2, S1END3,
    input  logic S2MID0, S2MID1, S2MID2, S2MID3, S2MID4, S2MID5, S2MID6, S2MID7,
    input  logic S2END0, S2END1, S2END2, S2END3, S2END4, S2END5, S2END6, S2END7,
    input  logic S4END0, S4END1, S4END2, S4END3, S4END4, S4END5, S4END6, S4END7,
    input  logic S4END8, S4END9, S4END10, S4END11, S4END12, S4END13, S4END14, S4END15,
    output logic N1BEG0, N1BEG1, N1BEG2, N1BEG3,
    output logic N2BEG0, N2BEG1, N2BEG2, N2BEG3, N2BEG4, N2BEG5, N2BEG6, N2BEG7,
    output logic N2BEGb0, N2BEGb1, N2BEGb2, N2BEGb3, N2BEGb4, N2BEGb5, N2BEGb6, N2BEGb7,
    output logic N4BEG0, N4BEG1, N4BEG2, N4BEG3, N4BEG4, N4BEG5, N4BEG6, N4BEG7,
    output logic N4BEG8, N4BEG9, N4BEG10, N4BEG11, N4BEG12, N4BEG13, N4BEG14, N4BEG15
);

    localparam logic [COUNT_WIDTH-1:0] LOAD_LEN  = COUNT_WIDTH'(NoConfigBits);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [3:0]  s1end;
    logic [7:0]  s2mid;
    logic [7:0]  s2end;
    logic [15:0] s4end;

    logic [WIRE_COUNT-1:0] src_mirror;
    logic [WIRE_COUNT-1:0] src_straight;
    logic [WIRE_COUNT-1:0] n_out;

    logic [NoConfigBits-1:0] sr;
    logic [NoConfigBits-1:0] active;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    cfg_ok;
    logic                    mode_q;
    logic                    mode_rise;
    logic                    mode_fall;
    logic                    out_en;

    assign s1end = {S1END3, S1END2, S1END1, S1END0};
    assign s2mid = {S2MID7, S2MID6, S2MID5, S2MID4, S2MID3, S2MID2, S2MID1, S2MID0};
    assign s2end = {S2END7, S2END6, S2END5, S2END4, S2END3, S2END2, S2END1, S2END0};
    assign s4end = {S4END15, S4END14, S4END13, S4END12, S4END11, S4END10, S4END9, S4END8,
                    S4END7, S4END6, S4END5, S4END4, S4END3, S4END2, S4END1, S4END0};

    assign mode_rise = MODE & ~mode_q;
    assign mode_fall = ~MODE & mode_q;
    assign out_en    = ~MODE & cfg_ok;
    assign CONFout   = sr[NoConfigBits-1];
    assign CFG_OK    = cfg_ok;

    // Wire-vector packing follows the group order: N1BEG, N2BEG, N2BEGb, N4BEG.
    assign src_straight = {s4end, s2end, s2mid, s1end};

    // Mirrored sources: each family is index-reversed within itself.
    always_comb begin
        src_mirror = '0;
        for (int i = 0; i < 4; i++) begin
            src_mirror[i] = s1end[3-i];
        end
        for (int i = 0; i < 8; i++) begin
            src_mirror[4+i]  = s2mid[7-i];
            src_mirror[12+i] = s2end[7-i];
        end
        for (int i = 0; i < 16; i++) begin
            src_mirror[20+i] = s4end[15-i];
        end
    end

    // Serial configuration chain; CONFout is always the chain's last bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr <= '0;
        end else if (MODE) begin
            sr <= {sr[NoConfigBits-2:0], CONFin};
        end
    end

    // Load control: count shifts of one MODE window (the rising edge restarts
    // the count and also counts its own shift), commit on the falling edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= 1'b0;
            count  <= '0;
            active <= '0;
            cfg_ok <= 1'b1;
        end else begin
            mode_q <= MODE;
            if (mode_rise) begin
                count <= COUNT_WIDTH'(1);
            end else if (MODE && count != COUNT_MAX) begin
                count <= count + COUNT_WIDTH'(1);
            end
            if (mode_fall) begin
                if (count == LOAD_LEN) begin
                    active <= sr;
                    cfg_ok <= 1'b1;
                end else begin
                    cfg_ok <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < GROUP_COUNT; g++) begin : g_group
        loopback_group4 u_group (
            .clk      (CLK),
            .rst      (RST),
            .mirror   (src_mirror[GROUP_WIDTH*g +: GROUP_WIDTH]),
            .straight (src_straight[GROUP_WIDTH*g +: GROUP_WIDTH]),
            .sel      (active[2*g +: 2]),
            .enable   (out_en),
            .out      (n_out[GROUP_WIDTH*g +: GROUP_WIDTH])
        );
    end

    assign {N1BEG3, N1BEG2, N1BEG1, N1BEG0} = n_out[3:0];
    assign {N2BEG7, N2BEG6, N2BEG5, N2BEG4, N2BEG3, N2BEG2, N2BEG1, N2BEG0} = n_out[11:4];
    assign {N2BEGb7, N2BEGb6, N2BEGb5, N2BEGb4,
            N2BEGb3, N2BEGb2, N2BEGb1, N2BEGb0} = n_out[19:12];
    assign {N4BEG15, N4BEG14, N4BEG13, N4BEG12, N4BEG11, N4BEG10, N4BEG9, N4BEG8,
            N4BEG7, N4BEG6, N4BEG5, N4BEG4, N4BEG3, N4BEG2, N4BEG1, N4BEG0} = n_out[35:20];

endmodule

// File: doc/s_term_ram_io_loopback.md
S_TERM_RAM_IO_LOOPBACK -- requirements
Module: s_term_ram_io_loopback

Interface
REQ-001 SHALL have parameter NoConfigBits, default 18, the configuration shift-chain length.
REQ-002 SHALL have port CLK, input, 1, the single block clock, rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port MODE, input, 1, config-load enable; 1 = shift CONFin.
REQ-005 SHALL have port CONFin, input, 1, serial config data.
REQ-006 SHALL have port CONFout, output, 1, serial config pass-through to the next tile.
REQ-007 SHALL have port CFG_OK, output, 1, active configuration valid.
REQ-008 SHALL have ports S1END0..3, S2MID0..7, S2END0..7 and S4END0..15, each input, 1, south-arriving wires.
REQ-009 SHALL have ports N1BEG0..3, N2BEG0..7, N2BEGb0..7 and N4BEG0..15, each output, 1, north-departing wires.

Function
REQ-010 SHALL group outputs into 9 groups of 4: G0=N1BEG0-3, G1=N2BEG0-3, G2=N2BEG4-7, G3=N2BEGb0-3, G4=N2BEGb4-7, G5..G8=N4BEG0-3/4-7/8-11/12-15.
REQ-011 SHALL define the mirrored source as N1BEG[i]<-S1END[3-i], N2BEG[i]<-S2MID[7-i], N2BEGb[i]<-S2END[7-i], N4BEG[i]<-S4END[15-i].
REQ-012 SHALL define the straight source as N*BEG[i]<-same-index S*END/S2MID.
REQ-013 SHALL select group k from active[2k+1:2k]: 00 mirrored combinational; 01 mirrored registered; 10 straight combinational; 11 constant 0.
REQ-014 SHALL have registered mode use one flop per output wire, capturing the mirrored source every CLK edge regardless of mode, giving 1-cycle latency.
REQ-015 SHALL, while MODE=1, shift sr <= {sr[16:0], CONFin} each edge and drive CONFout = sr[17]; CONFout SHALL be sr[17] at all times.
REQ-016 SHALL reset a 5-bit shift counter to 0 on the MODE 0->1 edge (detected on a registered MODE) and increment it per shift, saturating at 31.
REQ-017 SHALL, on the MODE 1->0 edge: when count==18, copy active<=sr and set CFG_OK=1; otherwise keep active unchanged and set CFG_OK=0.
REQ-018 SHALL drive all N* outputs to 0 while MODE=1 or CFG_OK=0.
REQ-019 SHALL apply a group-mode change on the cycle after the MODE fall; a change into registered mode outputs the flop's current content immediately.

Reset
REQ-020 SHALL, while RST=1, set sr=0, active=0 (all groups mirrored combinational), CFG_OK=1, counter=0, registered MODE=0, pipeline flops=0, CONFout=0.
REQ-021 SHALL abort a load when RST is asserted mid-load, with active reverting to 0.
REQ-022 SHALL produce, after reset with MODE=0, exactly the mirrored loopback on all 36 wires.

Structure
REQ-023 SHALL take group-mode encodings (MODE_MIRROR=00, MODE_MIRROR_REG=01, MODE_STRAIGHT=10, MODE_ZERO=11), group count 9 and chain length 18 from the shared fabric package.
REQ-024 SHALL instantiate one sub-module, loopback_group4 (4-bit mux plus 4 flops), 9 times.

Verification
REQ-025 SHALL cover: reset, MODE=0, S4END0=1, others 0 -> N4BEG15=1, all other outputs 0, CFG_OK=1.
REQ-026 SHALL cover: shift 18 bits making G1=01, all others 00, then drop MODE; toggle S2MID7 -> N2BEG0 follows exactly 1 cycle later; N1BEG follows combinationally.
REQ-027 SHALL cover: shift 17 bits then drop MODE -> CFG_OK=0, all outputs 0; a following 18-bit load -> CFG_OK=1.
REQ-028 SHALL cover: load G0=10 -> N1BEG2 follows S1END2; load G5=11 -> N4BEG0-3 stay 0 with S4END=all 1s.
REQ-029 SHALL cover: shift 0x2AAAA, then 18 more zeros -> CONFout emits 0x2AAAA MSB-first after an 18-cycle delay.
REQ-030 SHALL cover: RST pulse at shift 9 -> active=0, CFG_OK=1, mirrored loopback restored.
